// File: rtl/cfu_arbiter.sv
// Round-robin arbiter sharing one CFU (en/stall/rslt protocol) between two requesters.
// Latches the winner's operands, holds cfu_en_o until the CFU stops stalling, aborts hung ops.
module cfu_arbiter #(
  parameter  int unsigned TIMEOUT = 1024,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned F3_W    = 3,
  localparam int unsigned F7_W    = 7,
  localparam int unsigned XLEN    = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [F3_W-1:0] req0_funct3_i,
  input  logic [F7_W-1:0] req0_funct7_i,
  input  logic [XLEN-1:0] req0_src1_i,
  input  logic [XLEN-1:0] req0_src2_i,

  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [F3_W-1:0] req1_funct3_i,
  input  logic [F7_W-1:0] req1_funct7_i,
  input  logic [XLEN-1:0] req1_src1_i,
  input  logic [XLEN-1:0] req1_src2_i,

  output logic            rsp0_valid_o,
  output logic [XLEN-1:0] rsp0_rslt_o,
  output logic            rsp0_err_o,

  output logic            rsp1_valid_o,
  output logic [XLEN-1:0] rsp1_rslt_o,
  output logic            rsp1_err_o,

  output logic            cfu_en_o,
  output logic [F3_W-1:0] cfu_funct3_o,
  output logic [F7_W-1:0] cfu_funct7_o,
  output logic [XLEN-1:0] cfu_src1_o,
  output logic [XLEN-1:0] cfu_src2_o,
  input  logic            cfu_stall_i,
  input  logic [XLEN-1:0] cfu_rslt_i,

  output logic            busy_o
);

  localparam bit               WDOG_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WDOG_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [F7_W-1:0] funct7;
    logic [F3_W-1:0] funct3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
  } cfu_op_t;

  state_e           state_q;
  state_e           state_d;
  cfu_op_t          op_q;
  cfu_op_t          req0_op;
  cfu_op_t          req1_op;
  cfu_op_t          sel_op;
  logic             grant_q;
  logic             last_grant_q;
  logic             pick;
  logic             accept;
  logic             issue_done;
  logic             issue_abort;
  logic             finish;
  logic [CNT_W-1:0] wdog_q;

  logic             en_q;
  logic             busy_q;
  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_err_q;
  logic [XLEN-1:0]  rsp0_rslt_q;
  logic [XLEN-1:0]  rsp1_rslt_q;

  assign req0_op = '{funct7: req0_funct7_i, funct3: req0_funct3_i,
                     src1: req0_src1_i, src2: req0_src2_i};
  assign req1_op = '{funct7: req1_funct7_i, funct3: req1_funct3_i,
                     src1: req1_src1_i, src2: req1_src2_i};

  // Round-robin pick: on contention the port that did not win last time goes next.
  always_comb begin
    pick = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      pick = ~last_grant_q;
    end else begin
      pick = req1_valid_i;
    end
  end

  // Ready is gated by reset so no handshake completes on a cycle whose edge resets the block.
  assign accept       = (state_q == IDLE) && !rst_i && (req0_valid_i || req1_valid_i);
  assign req0_ready_o = accept && !pick;
  assign req1_ready_o = accept && pick;
  assign sel_op       = pick ? req1_op : req0_op;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_done  = 1'b0;
    issue_abort = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!cfu_stall_i) begin
          issue_done = 1'b1;
          state_d    = RESP;
        end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
          issue_abort = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign finish = issue_done || issue_abort;

  // Operand latch, grant bookkeeping and stall watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q         <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
    end else begin
      if (accept) begin
        op_q         <= sel_op;
        grant_q      <= pick;
        last_grant_q <= pick;
      end
      if ((state_q == ISSUE) && cfu_stall_i) begin
        wdog_q <= wdog_q + CNT_W'(1);
      end else if (state_q != ISSUE) begin
        wdog_q <= '0;
      end
    end
  end

  // Registered outputs; the response lands only on the granted port and is zero elsewhere.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp0_rslt_q <= '0;
      rsp1_rslt_q <= '0;
    end else begin
      en_q           <= (state_d == ISSUE);
      busy_q         <= (state_d != IDLE);
      rsp_valid_q[0] <= finish && !grant_q;
      rsp_valid_q[1] <= finish && grant_q;
      rsp_err_q[0]   <= issue_abort && !grant_q;
      rsp_err_q[1]   <= issue_abort && grant_q;
      rsp0_rslt_q    <= (issue_done && !grant_q) ? cfu_rslt_i : '0;
      rsp1_rslt_q    <= (issue_done && grant_q) ? cfu_rslt_i : '0;
    end
  end

  assign cfu_en_o     = en_q;
  assign cfu_funct3_o = op_q.funct3;
  assign cfu_funct7_o = op_q.funct7;
  assign cfu_src1_o   = op_q.src1;
  assign cfu_src2_o   = op_q.src2;

  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp0_rslt_o  = rsp0_rslt_q;
  assign rsp0_err_o   = rsp_err_q[0];
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp1_rslt_o  = rsp1_rslt_q;
  assign rsp1_err_o   = rsp_err_q[1];

  assign busy_o = busy_q;

endmodule

// File: tb/tb_cfu_arbiter.sv
// Bench for cfu_arbiter: directed scenarios plus randomized traffic, all checked each cycle
// against a transaction-level model of grants, issue windows and responses.
module tb_cfu_arbiter;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [2:0]  req0_funct3_i, req1_funct3_i;
  logic [6:0]  req0_funct7_i, req1_funct7_i;
  logic [31:0] req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i;
  logic        rsp0_valid_o, rsp1_valid_o, rsp0_err_o, rsp1_err_o;
  logic [31:0] rsp0_rslt_o, rsp1_rslt_o;
  logic        cfu_en_o, cfu_stall_i, busy_o;
  logic [2:0]  cfu_funct3_o;
  logic [6:0]  cfu_funct7_o;
  logic [31:0] cfu_src1_o, cfu_src2_o, cfu_rslt_i;

  cfu_arbiter #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_funct3_i(req0_funct3_i), .req0_funct7_i(req0_funct7_i),
    .req0_src1_i(req0_src1_i), .req0_src2_i(req0_src2_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_funct3_i(req1_funct3_i), .req1_funct7_i(req1_funct7_i),
    .req1_src1_i(req1_src1_i), .req1_src2_i(req1_src2_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_rslt_o(rsp0_rslt_o), .rsp0_err_o(rsp0_err_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_rslt_o(rsp1_rslt_o), .rsp1_err_o(rsp1_err_o),
    .cfu_en_o(cfu_en_o), .cfu_funct3_o(cfu_funct3_o), .cfu_funct7_o(cfu_funct7_o),
    .cfu_src1_o(cfu_src1_o), .cfu_src2_o(cfu_src2_o),
    .cfu_stall_i(cfu_stall_i), .cfu_rslt_i(cfu_rslt_i),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // CFU behaviour the bench emulates.
  function automatic logic [31:0] cfu_fn(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a | b;
      3'd1:    return a + b;
      3'd2:    return a ^ b;
      3'd3:    return a & b;
      default: return (a - b) ^ {25'd0, f7};
    endcase
  endfunction

  // ---------------- requester / CFU drivers ----------------
  bit          pend [2];
  logic [2:0]  p_f3 [2];
  logic [6:0]  p_f7 [2];
  logic [31:0] p_s1 [2];
  logic [31:0] p_s2 [2];
  bit          auto_refill = 1'b0;
  bit          rand_mode   = 1'b0;
  int          stall_len   = 0;
  int          cfu_cnt     = 0;

  logic        s_rdy [2];
  logic        s_rv  [2];
  logic        s_err [2];
  logic [31:0] s_rr  [2];
  logic        s_en, s_busy;
  logic [31:0] s_src1;

  task automatic set_req(input int p, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
    pend[p] = 1'b1;
    p_f3[p] = f3;
    p_f7[p] = f7;
    p_s1[p] = a;
    p_s2[p] = b;
  endtask

  task automatic new_req(input int p);
    set_req(p, 3'($urandom_range(0, 7)), 7'($urandom), $urandom, $urandom);
  endtask

  task automatic drive();
    req0_valid_i  = pend[0];
    req0_funct3_i = p_f3[0];
    req0_funct7_i = p_f7[0];
    req0_src1_i   = p_s1[0];
    req0_src2_i   = p_s2[0];
    req1_valid_i  = pend[1];
    req1_funct3_i = p_f3[1];
    req1_funct7_i = p_f7[1];
    req1_src1_i   = p_s1[1];
    req1_src2_i   = p_s2[1];
  endtask

  // CFU stalls for the first stall_len enable cycles, then returns its result.
  task automatic cfu_drive();
    if (cfu_en_o === 1'b1) begin
      if (cfu_cnt < stall_len) begin
        cfu_stall_i = 1'b1;
        cfu_rslt_i  = $urandom;
        cfu_cnt++;
      end else begin
        cfu_stall_i = 1'b0;
        cfu_rslt_i  = cfu_fn(cfu_funct3_o, cfu_funct7_o, cfu_src1_o, cfu_src2_o);
      end
    end else begin
      cfu_cnt     = 0;
      cfu_stall_i = 1'($urandom_range(0, 1));
      cfu_rslt_i  = $urandom;
    end
  endtask

  // One clock: sample outputs at negedge, then update drivers just after posedge.
  task automatic step();
    @(negedge clk);
    s_rdy[0] = req0_ready_o;  s_rdy[1] = req1_ready_o;
    s_rv[0]  = rsp0_valid_o;  s_rv[1]  = rsp1_valid_o;
    s_err[0] = rsp0_err_o;    s_err[1] = rsp1_err_o;
    s_rr[0]  = rsp0_rslt_o;   s_rr[1]  = rsp1_rslt_o;
    s_en     = cfu_en_o;
    s_busy   = busy_o;
    s_src1   = cfu_src1_o;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (s_rdy[p] === 1'b1) pend[p] = 1'b0;
      if (auto_refill && !pend[p]) new_req(p);
      if (rand_mode) begin
        if (!pend[p] && ($urandom_range(0, 3) == 0)) new_req(p);
        else if (pend[p] && ($urandom_range(0, 15) == 0)) pend[p] = 1'b0;
      end
    end
    if (rand_mode && ((s_rdy[0] === 1'b1) || (s_rdy[1] === 1'b1)))
      stall_len = $urandom_range(0, 9);
    drive();
    cfu_drive();
  endtask

  // ---------------- transaction-level reference model ----------------
  int          mcyc = 0;
  bit          armed = 1'b0;
  bit          in_flight, resp_known, last_grant;
  int          acc_cyc, resp_cyc, issue_n, m_port;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;
  logic [31:0] m_s1, m_s2, m_rslt;
  bit          m_err;

  always @(negedge clk) begin : model
    bit idle, v0, v1, e_rdy0, e_rdy1, issuing, e_rsp, e_busy, rv0, rv1;
    mcyc++;
    if (rst_i === 1'b1) begin
      armed      = 1'b1;
      in_flight  = 1'b0;
      resp_known = 1'b0;
      last_grant = 1'b1;
      m_f3 = '0; m_f7 = '0; m_s1 = '0; m_s2 = '0;
    end else if (armed) begin
      idle    = !in_flight;
      v0      = req0_valid_i;
      v1      = req1_valid_i;
      e_rdy0  = idle && v0 && (!v1 || last_grant);
      e_rdy1  = idle && v1 && (!v0 || !last_grant);
      issuing = in_flight && (mcyc > acc_cyc) && !resp_known;
      e_rsp   = in_flight && resp_known && (mcyc == resp_cyc);
      e_busy  = in_flight && (mcyc > acc_cyc);
      rv0     = e_rsp && (m_port == 0);
      rv1     = e_rsp && (m_port == 1);

      chk("ready0", 32'(req0_ready_o), 32'(e_rdy0));
      chk("ready1", 32'(req1_ready_o), 32'(e_rdy1));
      chk("cfu_en", 32'(cfu_en_o), 32'(issuing));
      chk("busy", 32'(busy_o), 32'(e_busy));
      chk("cfu_funct3", 32'(cfu_funct3_o), 32'(m_f3));
      chk("cfu_funct7", 32'(cfu_funct7_o), 32'(m_f7));
      chk("cfu_src1", cfu_src1_o, m_s1);
      chk("cfu_src2", cfu_src2_o, m_s2);
      chk("rsp0_valid", 32'(rsp0_valid_o), 32'(rv0));
      chk("rsp1_valid", 32'(rsp1_valid_o), 32'(rv1));
      chk("rsp0_rslt", rsp0_rslt_o, rv0 ? m_rslt : 32'd0);
      chk("rsp1_rslt", rsp1_rslt_o, rv1 ? m_rslt : 32'd0);
      if (rv0) chk("rsp0_err", 32'(rsp0_err_o), 32'(m_err));
      if (rv1) chk("rsp1_err", 32'(rsp1_err_o), 32'(m_err));

      if (e_rdy0 || e_rdy1) begin
        in_flight  = 1'b1;
        resp_known = 1'b0;
        acc_cyc    = mcyc;
        issue_n    = 0;
        m_port     = e_rdy1 ? 1 : 0;
        last_grant = e_rdy1;
        m_f3 = e_rdy1 ? req1_funct3_i : req0_funct3_i;
        m_f7 = e_rdy1 ? req1_funct7_i : req0_funct7_i;
        m_s1 = e_rdy1 ? req1_src1_i   : req0_src1_i;
        m_s2 = e_rdy1 ? req1_src2_i   : req0_src2_i;
      end else if (issuing) begin
        issue_n++;
        if (!cfu_stall_i) begin
          resp_known = 1'b1;
          resp_cyc   = mcyc + 1;
          m_rslt     = cfu_fn(m_f3, m_f7, m_s1, m_s2);
          m_err      = 1'b0;
        end else if ((TO != 0) && (issue_n == int'(TO))) begin
          resp_known = 1'b1;
          resp_cyc   = mcyc + 1;
          m_rslt     = 32'd0;
          m_err      = 1'b1;
        end
      end else if (e_rsp) begin
        in_flight = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  int order [$];
  int exp_ord [4] = '{0, 1, 0, 1};

  initial begin
    rst_i = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      p_f3[p] = '0; p_f7[p] = '0; p_s1[p] = '0; p_s2[p] = '0;
    end
    drive();
    cfu_stall_i = 1'b0;
    cfu_rslt_i  = '0;

    // Reset state
    step(); step();
    rst_i = 1'b0;
    step();
    chk("rst_en", 32'(s_en), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_rsp0", 32'(s_rv[0]), 32'd0);
    chk("rst_src1", s_src1, 32'd0);

    // Single req0, no stall
    stall_len = 0;
    set_req(0, 3'd0, 7'd0, 32'h0F0F_0000, 32'h0000_00F0);
    drive();
    step();
    chk("t1_ready0", 32'(s_rdy[0]), 32'd1);
    step();
    chk("t1_en", 32'(s_en), 32'd1);
    step();
    chk("t1_rsp0_valid", 32'(s_rv[0]), 32'd1);
    chk("t1_rsp0_rslt", s_rr[0], 32'h0F0F_00F0);
    chk("t1_rsp0_err", 32'(s_err[0]), 32'd0);
    chk("t1_rsp1_valid", 32'(s_rv[1]), 32'd0);
    chk("t1_model_rslt", m_rslt, 32'h0F0F_00F0);
    step();
    chk("t1_rsp0_pulse", 32'(s_rv[0]), 32'd0);

    // Single req1, three stall cycles
    stall_len = 3;
    set_req(1, 3'd1, 7'h11, 32'h1000_0000, 32'h0000_0234);
    drive();
    step();
    chk("t2_ready1", 32'(s_rdy[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_en", 32'(s_en), 32'd1);
      chk("t2_src1", s_src1, 32'h1000_0000);
      chk("t2_early_rsp", 32'(s_rv[1]), 32'd0);
    end
    step();
    chk("t2_rsp1_valid", 32'(s_rv[1]), 32'd1);
    chk("t2_rsp1_rslt", s_rr[1], 32'h1000_0234);
    chk("t2_rsp0_valid", 32'(s_rv[0]), 32'd0);
    step();
    chk("t2_rsp1_pulse", 32'(s_rv[1]), 32'd0);

    // Continuous contention from reset
    stall_len = 0;
    rst_i = 1'b1;
    auto_refill = 1'b1;
    new_req(0); new_req(1);
    drive();
    step(); step();
    rst_i = 1'b0;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      step();
      if (s_rdy[0] === 1'b1) order.push_back(0);
      if (s_rdy[1] === 1'b1) order.push_back(1);
    end
    auto_refill = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive();
    chk("t3_grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) chk("t3_grant_order", 32'(order[i]), 32'(exp_ord[i]));
    repeat (6) step();

    // Watchdog abort, then a normal op
    stall_len = 100;
    set_req(0, 3'd2, 7'd0, 32'hDEAD_0000, 32'h0000_BEEF);
    drive();
    step();
    chk("t4_ready0", 32'(s_rdy[0]), 32'd1);
    for (int i = 0; i < int'(TO); i++) begin
      step();
      chk("t4_en", 32'(s_en), 32'd1);
    end
    step();
    chk("t4_rsp0_valid", 32'(s_rv[0]), 32'd1);
    chk("t4_rsp0_err", 32'(s_err[0]), 32'd1);
    chk("t4_rsp0_rslt", s_rr[0], 32'd0);
    chk("t4_en_drop", 32'(s_en), 32'd0);
    stall_len = 0;
    set_req(1, 3'd0, 7'd0, 32'hA000_0000, 32'h0000_000A);
    drive();
    step();
    chk("t4_ready1", 32'(s_rdy[1]), 32'd1);
    step(); step();
    chk("t4_rsp1_valid", 32'(s_rv[1]), 32'd1);
    chk("t4_rsp1_rslt", s_rr[1], 32'hA000_000A);
    chk("t4_rsp1_err", 32'(s_err[1]), 32'd0);
    step();

    // Reset during the second ISSUE cycle of a stalled op
    stall_len = 100;
    set_req(0, 3'd1, 7'd0, 32'd1, 32'd2);
    drive();
    step();
    chk("t5_ready0", 32'(s_rdy[0]), 32'd1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    stall_len = 0;
    set_req(0, 3'd3, 7'd5, 32'hFFFF_0000, 32'h0F0F_0F0F);
    set_req(1, 3'd2, 7'd6, 32'h1234_5678, 32'h1111_1111);
    drive();
    step();
    chk("t5_en", 32'(s_en), 32'd0);
    chk("t5_busy", 32'(s_busy), 32'd0);
    chk("t5_rsp0", 32'(s_rv[0]), 32'd0);
    chk("t5_rsp1", 32'(s_rv[1]), 32'd0);
    chk("t5_ready0", 32'(s_rdy[0]), 32'd1);
    chk("t5_ready1", 32'(s_rdy[1]), 32'd0);
    repeat (12) step();

    // Randomized traffic with occasional resets
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_i = 1'b0;
    rand_mode = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive();
    for (int i = 0; i < 50; i++) begin
      step();
      if (s_busy === 1'b0) break;
    end
    chk("drain_busy", 32'(s_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfu_arbiter.md
Name: cfu_arbiter

Overview:
- Shares one CFU instance (en/stall/rslt protocol) between two requesters, e.g. the CPU custom-instruction path (port 0) and a DMA/accelerator engine (port 1).
- Round-robin arbitration; latches the winner's operands; holds the CFU enable until the CFU stops stalling; returns a registered result to the winning port only.
- A stall watchdog aborts operations that hang.
- Sits between the requesters and the cfu module; the CFU sees a single well-formed issuer.

Parameters:
- TIMEOUT, 1024: max cycles cfu_en_o may be held with cfu_stall_i high before abort; 0 disables the watchdog.
- CNT_W, 16: watchdog counter width; TIMEOUT must be < 2**CNT_W.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- reqN_valid_i  in  1  request valid, N=0,1; held with operands until accepted
- reqN_ready_o  out  1  request accepted this cycle (valid&&ready)
- reqN_funct3_i  in  3  funct3 for requester N
- reqN_funct7_i  in  7  funct7 for requester N
- reqN_src1_i  in  32  operand 1
- reqN_src2_i  in  32  operand 2
- rspN_valid_o  out  1  one-cycle response pulse to requester N
- rspN_rslt_o  out  32  result; valid with rspN_valid_o, 0 otherwise
- rspN_err_o  out  1  with rspN_valid_o: 1 = watchdog abort
- cfu_en_o  out  1  CFU enable
- cfu_funct3_o  out  3  latched funct3
- cfu_funct7_o  out  7  latched funct7
- cfu_src1_o  out  32  latched src1
- cfu_src2_o  out  32  latched src2
- cfu_stall_i  in  1  CFU busy
- cfu_rslt_i  in  32  CFU result; sampled when cfu_en_o=1 && cfu_stall_i=0
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (sync, rst_i=1 at a clock edge): state=IDLE, cfu_en_o=0, all rsp*/ready=0, latched operands=0, watchdog=0, last_grant=1 (port 0 wins first). An in-flight op is discarded with no response; cfu_en_o is 0 from the first cycle after reset.
- States: IDLE, ISSUE, RESP.
- IDLE: reqN_ready_o is combinational and asserted only in IDLE.
  - One port valid: that port gets ready.
  - Both valid: the port != last_grant gets ready; the other sees ready=0.
  - On accept: latch funct3/funct7/src1/src2 and grant id, set last_grant=id, go to ISSUE.
- ISSUE: cfu_en_o=1; operand outputs are stable for the whole state.
  - cfu_stall_i=0: capture cfu_rslt_i, err=0, go to RESP.
  - cfu_stall_i=1: increment watchdog. If TIMEOUT!=0 and watchdog==TIMEOUT-1 while stall is still high: result=0, err=1, go to RESP. cfu_en_o drops the next cycle.
- RESP: rsp<grant>_valid_o=1 for exactly one cycle with the registered rslt/err; other port's rsp outputs stay 0; watchdog cleared; go to IDLE.
- Latency: accept at cycle N; ISSUE from N+1; with no stall, response at N+2; next accept earliest N+3. Each stall cycle adds one cycle.
- Operand outputs retain their last latched value outside ISSUE; only cfu_en_o qualifies them.
- A requester dropping valid before ready is legal; no request is recorded.
- Requests arriving in ISSUE/RESP wait; ready=0.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.

Test Plan:
- Reset, then req0 valid (funct3=0, src1=0x0F0F0000, src2=0x000000F0); CFU model rslt=src1|src2, stall=0 -> ready0 at N, cfu_en_o at N+1, rsp0_valid at N+2 with 0x0F0F00F0, err=0; rsp1 stays 0.
- req1 alone; CFU stalls 3 cycles -> cfu_en_o high 4 cycles with stable operands; rsp1_valid at N+5; single pulse.
- req0 and req1 both valid from reset, held continuously -> order 0,1,0,1 over 4 ops, each result routed to its own port; loser's ready=0 until its grant.
- TIMEOUT=8; CFU stall held high -> abort after 8 ISSUE cycles: rsp valid, err=1, rslt=0. Next request with stall=0 completes normally.
- rst_i asserted during the second ISSUE cycle of a stalled op -> cfu_en_o=0 and busy_o=0 the next cycle; no rsp pulse. Following req0 is granted first (last_grant=1).
